stage_if: RTL and testbench



---
 rtl/stage_if_pkg.sv | 26 ++
 rtl/stage_if_fetch_fifo.sv | 68 ++++++
 rtl/stage_if.sv | 142 ++++++++++++++
 tb/tb_stage_if.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_if_pkg.sv
// Shared widths, defaults, state encoding and fetch-buffer payload for the IF stage.
package stage_if_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;

  localparam logic [INST_W-1:0]      NOP_INST_DEFAULT = 32'h0000_0013;
  localparam logic [INST_ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_WAIT = 2'd1,
    IF_DROP = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } fetch_entry_t;

  // Instruction addresses are word aligned; low two bits are forced to zero.
  function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] a);
    return {a[INST_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/stage_if_fetch_fifo.sv
// Small power-of-two FIFO of {pc, inst} entries between the fetch FSM and the decode register.
module fetch_fifo
  import stage_if_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  fetch_entry_t     wdata,
  output fetch_entry_t     head_c,
  output logic [CNT_W-1:0] count,
  output logic             full_c,
  output logic             empty_c
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Clear wins over any push/pop in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= wdata;
  end

  assign head_c  = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == '0);

  overflow_chk : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full_c && !pop && !clear));
  underflow_chk : assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && empty_c && !clear));

endmodule

// File: rtl/stage_if.sv
// Instruction-fetch stage: sequential word fetch over req/ack, buffered and presented to decode.
module stage_if
  import stage_if_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned            FIFO_DEPTH = 2,
  parameter logic [INST_W-1:0]      NOP_INST   = NOP_INST_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [INST_ADDR_W-1:0] flush_pc,
  output logic                   imem_req,
  output logic [INST_ADDR_W-1:0] imem_addr,
  input  logic                   imem_ack,
  input  logic [INST_W-1:0]      imem_rdata,
  output logic [INST_ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0]      if_inst,
  output logic                   if_valid
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  if_state_e              state_q, state_d;
  logic [INST_ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [INST_ADDR_W-1:0] addr_q, addr_d;
  logic                   req_q, req_d;
  logic [INST_ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [INST_W-1:0]      if_inst_q, if_inst_d;
  logic                   if_valid_q, if_valid_d;

  logic                   push_c;
  logic                   pop_c;
  logic [CNT_W-1:0]       fifo_count;
  logic [CNT_W-1:0]       post_count_c;
  logic                   fifo_full_c;
  logic                   fifo_empty_c;
  fetch_entry_t           head_c;
  fetch_entry_t           push_entry_c;
  logic [INST_ADDR_W-1:0] flush_pc_c;

  assign flush_pc_c   = word_align(flush_pc);
  assign pop_c        = !flush && !stall && !fifo_empty_c;
  assign push_entry_c = '{pc: addr_q, inst: imem_rdata};

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_c),
    .pop     (pop_c),
    .clear   (flush),
    .wdata   (push_entry_c),
    .head_c  (head_c),
    .count   (fifo_count),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c)
  );

  // Fetch FSM; during WAIT the outstanding address always equals fetch_pc_q.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    addr_d       = addr_q;
    push_c       = 1'b0;
    post_count_c = fifo_count + CNT_W'(1) - CNT_W'(pop_c);
    case (state_q)
      IF_IDLE: begin
        if (flush) begin
          fetch_pc_d = flush_pc_c;
        end else if (fifo_count < CNT_W'(FIFO_DEPTH)) begin
          state_d = IF_WAIT;
          addr_d  = fetch_pc_q;
        end
      end
      IF_WAIT: begin
        if (flush) begin
          fetch_pc_d = flush_pc_c;
          state_d    = imem_ack ? IF_IDLE : IF_DROP;
        end else if (imem_ack) begin
          push_c     = 1'b1;
          fetch_pc_d = fetch_pc_q + INST_ADDR_W'(4);
          if (post_count_c < CNT_W'(FIFO_DEPTH)) addr_d = fetch_pc_q + INST_ADDR_W'(4);
          else                                   state_d = IF_IDLE;
        end
      end
      IF_DROP: begin
        if (flush)    fetch_pc_d = flush_pc_c;
        if (imem_ack) state_d    = IF_IDLE;
      end
      default: state_d = IF_IDLE;
    endcase
    req_d = (state_d != IF_IDLE);
  end

  // Decode-facing register: flush beats stall, an empty buffer presents a NOP.
  always_comb begin
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;
    if (flush) begin
      if_valid_d = 1'b0;
      if_inst_d  = NOP_INST;
    end else if (!stall) begin
      if (!fifo_empty_c) begin
        if_pc_d    = head_c.pc;
        if_inst_d  = head_c.inst;
        if_valid_d = 1'b1;
      end else begin
        if_valid_d = 1'b0;
        if_inst_d  = NOP_INST;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IF_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      if_pc_q    <= '0;
      if_inst_q  <= NOP_INST;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign if_pc     = if_pc_q;
  assign if_inst   = if_inst_q;
  assign if_valid  = if_valid_q;

endmodule

// File: tb/tb_stage_if.sv
// Scoreboard bench for stage_if: acked words queue expected decode outputs, a monitor checks each cycle.
module tb_stage_if;
  import stage_if_pkg::*;

  localparam int unsigned DEPTH  = 2;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  stage_if #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Memory: answers a request after lat_cur wait cycles with address-derived data.
  int lat_fix = 0;
  int lat_cur = 0;
  int wcnt    = 0;
  initial forever begin
    @(negedge clk);
    if (!imem_req) begin
      wcnt       = 0;
      imem_ack   = ($urandom_range(3) == 0);
      imem_rdata = $urandom;
    end else if (wcnt >= lat_cur) begin
      imem_ack   = 1'b1;
      imem_rdata = mem_word(imem_addr);
      wcnt       = 0;
      lat_cur    = (lat_fix < 0) ? int'($urandom_range(3)) : lat_fix;
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      wcnt++;
    end
  end

  // Reference model: instruction stream as a queue of words already returned by memory.
  fetch_entry_t q[$];
  logic [31:0]  stream_pc  = RST_PC;
  logic [31:0]  stale_addr = '0;
  logic         stale      = 1'b0;
  logic         exp_req    = 1'b0;
  logic         exp_valid  = 1'b0;
  logic [31:0]  exp_pc     = '0;
  logic [31:0]  exp_inst   = NOP;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete();
      stream_pc = RST_PC;
      stale     = 1'b0;
      exp_req   = 1'b0;
      exp_valid = 1'b0;
      exp_pc    = '0;
      exp_inst  = NOP;
    end else begin
      int unsigned pre;
      fetch_entry_t e;
      logic m_req;
      m_req = exp_req;
      pre   = q.size();
      if (flush) begin
        q.delete();
        exp_valid = 1'b0;
        exp_inst  = NOP;
      end else if (!stall) begin
        if (pre > 0) begin
          e = q.pop_front();
          exp_pc    = e.pc;
          exp_inst  = e.inst;
          exp_valid = 1'b1;
        end else begin
          exp_valid = 1'b0;
          exp_inst  = NOP;
        end
      end
      if (flush) begin
        if (m_req && !stale) stale_addr = stream_pc;
        stale     = m_req && !imem_ack;
        stream_pc = {flush_pc[31:2], 2'b00};
        exp_req   = stale;
      end else if (!m_req) begin
        exp_req = (pre < DEPTH);
      end else if (!imem_ack) begin
        exp_req = 1'b1;
      end else if (stale) begin
        stale   = 1'b0;
        exp_req = 1'b0;
      end else begin
        q.push_back('{pc: stream_pc, inst: mem_word(stream_pc)});
        stream_pc = stream_pc + 32'd4;
        exp_req   = (q.size() < DEPTH);
      end
    end
  end

  // Monitor: every cycle the registered outputs must match the model.
  initial forever begin
    @(negedge clk);
    chk("if_valid", 32'(if_valid), 32'(exp_valid));
    chk("if_pc", if_pc, exp_pc);
    chk("if_inst", if_inst, exp_inst);
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", imem_addr, stale ? stale_addr : stream_pc);
  end

  task automatic wait_valid(input string name, input logic [31:0] want);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (if_valid) begin found = 1'b1; break; end
    end
    if (found) chk(name, if_pc, want);
    else       chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_req(input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (imem_req) begin found = 1'b1; break; end
    end
    if (!found) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    logic found;
    // reset state and zero-wait startup
    repeat (3) @(negedge clk);
    #1;
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_inst", if_inst, NOP);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", imem_addr, RST_PC);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("start_valid", 32'(if_valid), 32'd1);
    chk("start_pc0", if_pc, 32'h0);
    @(negedge clk); #1;
    chk("start_pc4", if_pc, 32'h4);
    @(negedge clk); #1;
    chk("start_pc8", if_pc, 32'h8);
    repeat (5) @(negedge clk);

    // stall for 5 cycles: buffer fills, request drops
    #1 stall = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("stall_req_low", 32'(imem_req), 32'd0);
    stall = 1'b0;
    repeat (6) @(negedge clk);

    // slow memory, flush during the second cycle of a request
    lat_fix = 3;
    lat_cur = 3;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (imem_req && wcnt == 2) begin found = 1'b1; break; end
    end
    if (!found) chk("drop_setup_timeout", 32'd0, 32'd1);
    flush = 1'b1; flush_pc = 32'h100;
    @(negedge clk); #1;
    flush = 1'b0;
    chk("drop_req_held", 32'(imem_req), 32'd1);
    wait_valid("drop_first_pc", 32'h100);
    repeat (4) @(negedge clk);

    // flush coinciding with an ack
    lat_fix = 0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (imem_req && imem_ack) begin found = 1'b1; break; end
    end
    if (!found) chk("ackflush_setup_timeout", 32'd0, 32'd1);
    flush = 1'b1; flush_pc = 32'h200;
    @(negedge clk); #1;
    flush = 1'b0;
    wait_req("ackflush_req");
    chk("ackflush_addr", imem_addr, 32'h200);
    wait_valid("ackflush_first_pc", 32'h200);
    repeat (3) @(negedge clk);

    // flush together with stall
    #1 stall = 1'b1; flush = 1'b1; flush_pc = 32'h300;
    @(negedge clk); #1;
    chk("flushstall_valid", 32'(if_valid), 32'd0);
    chk("flushstall_inst", if_inst, NOP);
    stall = 1'b0; flush = 1'b0;
    repeat (6) @(negedge clk);

    // address wrap
    #1 flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
    @(negedge clk); #1;
    flush = 1'b0;
    wait_valid("wrap_pc_hi", 32'hFFFF_FFFC);
    @(negedge clk); #1;
    chk("wrap_pc_lo", if_pc, 32'h0);
    repeat (4) @(negedge clk);

    // asynchronous reset in the middle of a request
    lat_fix = 3;
    lat_cur = 3;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (imem_req && wcnt == 1) begin found = 1'b1; break; end
    end
    if (!found) chk("areset_setup_timeout", 32'd0, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("areset_req", 32'(imem_req), 32'd0);
    chk("areset_valid", 32'(if_valid), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    wait_req("areset_restart");
    chk("areset_restart_addr", imem_addr, RST_PC);
    repeat (4) @(negedge clk);

    // randomized traffic
    lat_fix = -1;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk); #1;
      stall = ($urandom_range(9) < 3);
      flush = ($urandom_range(19) == 0);
      if ($urandom_range(3) == 0) flush_pc = 32'hFFFF_FFF0 + 32'($urandom_range(15));
      else                        flush_pc = $urandom;
    end
    @(negedge clk); #1;
    stall = 1'b0;
    flush = 1'b0;
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
